// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-tick divider, h/v counters, active-video enable,
// delayed hsync/vsync and one-clk line/frame start strobes.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       px_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       ACT    = (SYNC_POL != 0);

  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_px_tick;
  logic [9:0]       r_h, r_v, w_h_nxt, w_v_nxt;
  logic             r_en, r_ls, r_fs;
  logic             w_h_wrap, w_v_wrap, w_hs_raw, w_vs_raw;

  always_comb begin
    w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_h_wrap  = (r_h == H_LAST);
    w_v_wrap  = (r_v == V_LAST);
    w_h_nxt   = r_h;
    w_v_nxt   = r_v;
    if (r_px_tick) begin
      w_h_nxt = w_h_wrap ? 10'd0 : r_h + 10'd1;
      if (w_h_wrap) w_v_nxt = w_v_wrap ? 10'd0 : r_v + 10'd1;
    end
    w_hs_raw = ((r_h >= HS_BEG) && (r_h < HS_END)) ? ACT : !ACT;
    w_vs_raw = ((r_v >= VS_BEG) && (r_v < VS_END)) ? ACT : !ACT;
  end

  // px_tick is registered from the next divider value so it is low during reset
  // even when CLK_DIV=1; enable is likewise computed from the next counter values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_px_tick <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_en      <= 1'b0;
      r_ls      <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_div     <= w_div_nxt;
      r_px_tick <= (w_div_nxt == DIV_LAST);
      r_h       <= w_h_nxt;
      r_v       <= w_v_nxt;
      r_en      <= (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
      r_ls      <= r_px_tick && w_h_wrap;
      r_fs      <= r_px_tick && w_h_wrap && w_v_wrap;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hsync = w_hs_raw;
      assign vsync = w_vs_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] r_hs_pipe, r_vs_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hs_pipe <= ACT ? '0 : '1;
          r_vs_pipe <= ACT ? '0 : '1;
        end else begin
          r_hs_pipe[0] <= w_hs_raw;
          r_vs_pipe[0] <= w_vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            r_hs_pipe[i] <= r_hs_pipe[i-1];
            r_vs_pipe[i] <= r_vs_pipe[i-1];
          end
        end
      end
      assign hsync = r_hs_pipe[SYNC_DELAY-1];
      assign vsync = r_vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign px_tick     = r_px_tick;
  assign x           = r_h;
  assign y           = r_v;
  assign enable      = r_en;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three small-raster instances checked every clk against an arithmetic model:
// pixel index = clks since reset release / CLK_DIV, then h/v from div/mod.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       px;
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n = 0;
  int ep = 0;
  bit running = 1'b0;

  logic       a_px, a_en, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_px, b_en, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_px, c_en, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  obs_t oa, ob, oc;
  assign oa = {a_px, a_x, a_y, a_en, a_hs, a_vs, a_ls, a_fs};
  assign ob = {b_px, b_x, b_y, b_en, b_hs, b_vs, b_ls, b_fs};
  assign oc = {c_px, c_x, c_y, c_en, c_hs, c_vs, c_ls, c_fs};

  vga_timing_gen #(.CLK_DIV(4), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0), .SYNC_DELAY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .px_tick(a_px), .x(a_x), .y(a_y), .enable(a_en),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1), .SYNC_DELAY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .px_tick(b_px), .x(b_x), .y(b_y), .enable(b_en),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs));

  vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0), .SYNC_DELAY(3)) u_c (
    .clk(clk), .rst_n(rst_n), .px_tick(c_px), .x(c_x), .y(c_y), .enable(c_en),
    .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs));

  // n = rising edges since reset release; 0 while in reset
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  function automatic int pix(int k, int d);
    if (k <= 0) return 0;
    return (d == 1) ? k - 1 : k / d;
  endfunction

  function automatic obs_t model(int k, int d, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, int sp, int sd);
    obs_t o;
    int ht, vt, p, h, v, m, hm, vm;
    logic act;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    act = (sp != 0);
    p   = pix(k, d);
    h   = p % ht;
    v   = (p / ht) % vt;
    o.px = (k >= 1) && ((d == 1) || (k % d == d - 1));
    o.x  = 10'(h);
    o.y  = 10'(v);
    o.en = (k >= 1) && (h < ha) && (v < va);
    o.ls = (k >= 1) && (p != pix(k - 1, d)) && (h == 0);
    o.fs = o.ls && (v == 0);
    if (k < sd) begin
      o.hs = !act;
      o.vs = !act;
    end else begin
      m  = pix(k - sd, d);
      hm = m % ht;
      vm = (m / ht) % vt;
      o.hs = ((hm >= ha + hf) && (hm < ha + hf + hsw)) ? act : !act;
      o.vs = ((vm >= va + vf) && (vm < va + vf + vsw)) ? act : !act;
    end
    return o;
  endfunction

  task automatic cmp(string name, obs_t got, obs_t exp, int k);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%h (px=%b x=%0d y=%0d en=%b hs=%b vs=%b ls=%b fs=%b) want=%h (px=%b x=%0d y=%0d en=%b hs=%b vs=%b ls=%b fs=%b)",
        name, k, got, got.px, got.x, got.y, got.en, got.hs, got.vs, got.ls, got.fs,
        exp, exp.px, exp.x, exp.y, exp.en, exp.hs, exp.vs, exp.ls, exp.fs);
    end
  endtask

  task automatic lit(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(int k);
    cmp("instA", oa, model(k, 4, 20, 4, 6, 5, 8, 2, 2, 3, 0, 1), k);
    cmp("instB", ob, model(k, 1, 10, 2, 3, 2, 4, 1, 1, 2, 1, 0), k);
    cmp("instC", oc, model(k, 3, 6, 2, 2, 2, 3, 1, 1, 1, 0, 3), k);
  endtask

  always @(negedge clk) begin
    if (running) begin
      check_all(n);
      if (ep == 0) begin
        case (n)
          2:    lit("A_px_n2", int'(a_px), 0);
          3:    lit("A_first_px_n3", int'(a_px), 1);
          96:   begin lit("A_x_656eq", int'(a_x), 24); lit("A_hs_before", int'(a_hs), 1); end
          97:   lit("A_hs_fall", int'(a_hs), 0);
          120:  lit("A_hs_last_low", int'(a_hs), 0);
          121:  lit("A_hs_rise", int'(a_hs), 1);
          140:  begin lit("A_ls", int'(a_ls), 1); lit("A_ls_x", int'(a_x), 0); lit("A_ls_y", int'(a_y), 1); end
          141:  lit("A_ls_once", int'(a_ls), 0);
          1400: lit("A_vs_before", int'(a_vs), 1);
          1401: lit("A_vs_fall", int'(a_vs), 0);
          1680: lit("A_vs_last_low", int'(a_vs), 0);
          1681: lit("A_vs_rise", int'(a_vs), 1);
          2100: begin lit("A_fs", int'(a_fs), 1); lit("A_fs_y", int'(a_y), 0); end
          default: ;
        endcase
        case (n)
          1:  lit("B_px_const", int'(b_px), 1);
          12: lit("B_hs_pre", int'(b_hs), 0);
          13: lit("B_hs_on_x12", int'(b_hs), 1);
          15: lit("B_hs_on_x14", int'(b_hs), 1);
          16: lit("B_hs_off", int'(b_hs), 0);
          default: ;
        endcase
      end
    end
  end

  initial begin
    running = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    lit("rst_x", int'(a_x), 0);
    lit("rst_hs", int'(a_hs), 1);
    lit("rst_en", int'(a_en), 0);
    #2 rst_n = 1'b1;
    repeat (2300) @(negedge clk);
    for (int e = 1; e <= 6; e++) begin
      ep = e;
      #2 rst_n = 1'b0;
      #1 check_all(n);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat ($urandom_range(50, 3000)) @(negedge clk);
    end
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
